// File: rtl/clock_select_sequencer.sv
// Configuration registers and glitch-free channel switch for the 4-channel divided-clock generator.
// clk_out is a registered copy of the selected tap, gated low while a switch hands over between channels.
module clock_select_sequencer #(
  parameter logic [5:0] RESET_FACTOR = 6'd3,
  parameter logic [1:0] RESET_SEL    = 2'd0,
  parameter logic [7:0] TIMEOUT      = 8'd255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [2:0]  cfg_addr,
  input  logic [5:0]  cfg_data,
  input  logic [3:0]  div_clock,
  output logic [23:0] div_factor,
  output logic [1:0]  sel_active,
  output logic        clk_out,
  output logic        busy,
  output logic        timeout_flag
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DRAIN    = 2'd1,
    WAIT_NEW = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [3:0][5:0] factor_q, factor_d;
  logic [1:0]      sel_active_q, sel_active_d;
  logic [1:0]      sel_pending_q, sel_pending_d;
  logic            clk_out_q, clk_out_d;
  logic [7:0]      to_cnt_q, to_cnt_d;
  logic            flag_q, flag_d;
  logic            old_lvl, new_lvl, timeout_hit;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign old_lvl     = div_clock[sel_active_q];
  assign new_lvl     = div_clock[sel_pending_q];
  // The switch is forced on the edge where the counter would reach TIMEOUT.
  assign timeout_hit = (sat_inc(to_cnt_q) >= TIMEOUT);

  always_comb begin
    state_d       = state_q;
    factor_d      = factor_q;
    sel_active_d  = sel_active_q;
    sel_pending_d = sel_pending_q;
    clk_out_d     = 1'b0;
    to_cnt_d      = to_cnt_q;
    flag_d        = flag_q;
    case (state_q)
      IDLE: begin
        clk_out_d = old_lvl;
        if (cfg_valid) begin
          case (cfg_addr)
            3'd0, 3'd1, 3'd2, 3'd3: factor_d[cfg_addr[1:0]] = cfg_data;
            3'd4: begin
              if (cfg_data[1:0] != sel_active_q) begin
                sel_pending_d = cfg_data[1:0];
                state_d       = DRAIN;
                to_cnt_d      = 8'd0;
              end
            end
            3'd5:    flag_d = 1'b0;
            default: ;
          endcase
        end
      end
      DRAIN: begin
        to_cnt_d = sat_inc(to_cnt_q);
        if (!old_lvl) begin
          state_d = WAIT_NEW;
        end else if (timeout_hit) begin
          sel_active_d = sel_pending_q;
          state_d      = IDLE;
          flag_d       = 1'b1;
        end else begin
          clk_out_d = old_lvl;
        end
      end
      WAIT_NEW: begin
        to_cnt_d = sat_inc(to_cnt_q);
        if (!new_lvl) begin
          sel_active_d = sel_pending_q;
          state_d      = IDLE;
        end else if (timeout_hit) begin
          sel_active_d = sel_pending_q;
          state_d      = IDLE;
          flag_d       = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      factor_q      <= {4{RESET_FACTOR}};
      sel_active_q  <= RESET_SEL;
      sel_pending_q <= RESET_SEL;
      clk_out_q     <= 1'b0;
      to_cnt_q      <= 8'd0;
      flag_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      factor_q      <= factor_d;
      sel_active_q  <= sel_active_d;
      sel_pending_q <= sel_pending_d;
      clk_out_q     <= clk_out_d;
      to_cnt_q      <= to_cnt_d;
      flag_q        <= flag_d;
    end
  end

  assign cfg_ready    = (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign div_factor   = factor_q;
  assign sel_active   = sel_active_q;
  assign clk_out      = clk_out_q;
  assign timeout_flag = flag_q;

endmodule
